// File: rtl/vga_pkg.sv
// Shared types, bar colours and raster-size helper for the VGA timing generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRID   = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_STREAM = 2'd2,
    MODE_BLACK  = 2'd3
  } mode_t;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  // Total pixels per line or lines per frame: porch + sync + porch + active.
  function automatic int raster_tot(input int fp, input int pulse, input int bp, input int disp);
    return fp + pulse + bp + disp;
  endfunction

  // Colour of bar idx, left to right.
  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = C_WHITE;
      3'd1:    c = C_YELLOW;
      3'd2:    c = C_CYAN;
      3'd3:    c = C_GREEN;
      3'd4:    c = C_MAGENTA;
      3'd5:    c = C_RED;
      3'd6:    c = C_BLUE;
      default: c = C_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_if.sv
// Display-side video bundle: pixel clock, RGB, syncs and display-enable.
// Latency: n/a (wiring only).
// Backpressure: none, the display always accepts.
interface video_if;
  logic        CLK;
  logic [23:0] RGB;
  logic        HS;
  logic        VS;
  logic        BLANK;

  modport master (output CLK, output RGB, output HS, output VS, output BLANK);
  modport slave  (input  CLK, input  RGB, input  HS, input  VS, input  BLANK);
endinterface

// File: rtl/vga_raster_cnt.sv
// Pixel/line raster counters; pcnt wraps at HTOT-1, lcnt advances on each pcnt wrap.
// Latency: counters update every clock; frame wrap flag is combinational from them.
// Backpressure: none, the raster free-runs.
module vga_raster_cnt #(
  parameter int HTOT = 22,
  parameter int VTOT = 7,
  localparam int HW = $clog2(HTOT),
  localparam int VW = $clog2(VTOT)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_pcnt,
  output logic [VW-1:0] o_lcnt,
  output logic          o_frame_wrap
);

  logic [HW-1:0] r_pcnt;
  logic [VW-1:0] r_lcnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_pcnt == HW'(HTOT - 1));
  assign w_frame_end = w_line_end && (r_lcnt == VW'(VTOT - 1));

  // Advance pixel counter every clock; line counter steps when the line ends.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pcnt <= '0;
      r_lcnt <= '0;
    end else if (w_line_end) begin
      r_pcnt <= '0;
      r_lcnt <= w_frame_end ? '0 : r_lcnt + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  assign o_pcnt       = r_pcnt;
  assign o_lcnt       = r_lcnt;
  assign o_frame_wrap = w_frame_end;

endmodule

// File: rtl/vga_gen.sv
// VGA/LCD timing generator with grid / bars / stream / black pixel sources.
// Latency: HS, VS, BLANK, RGB and frame_start are registered, 1 cycle behind the counters.
// Backpressure: none; pix_ready is a pure raster strobe and a missing pixel becomes black + underflow.
module vga_gen
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  video_if.master     video_ifm
);

  localparam int HTOT   = raster_tot(HFP, HPULSE, HBP, HDISP);
  localparam int VTOT   = raster_tot(VFP, VPULSE, VBP, VDISP);
  localparam int HW     = $clog2(HTOT);
  localparam int VW     = $clog2(VTOT);
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int BAR_W  = HDISP / 8;

  logic [HW-1:0] w_pcnt;
  logic [VW-1:0] w_lcnt;
  logic          w_frame_wrap;
  logic [31:0]   w_p32;
  logic [31:0]   w_l32;
  logic [31:0]   w_x32;
  logic [31:0]   w_y32;
  logic [31:0]   w_bar32;
  logic [2:0]    w_bar_idx;
  logic          w_active;
  logic          w_hs_act;
  logic          w_vs_act;
  logic          w_first;
  logic          w_starve;
  logic [23:0]   w_rgb_nxt;

  mode_t         r_cur_mode;
  logic          r_origin;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [23:0]   r_rgb;
  logic          r_fs;
  logic          r_uf;

  vga_raster_cnt #(
    .HTOT (HTOT),
    .VTOT (VTOT)
  ) u_cnt (
    .i_clk        (pixel_clk),
    .i_rst        (pixel_rst),
    .o_pcnt       (w_pcnt),
    .o_lcnt       (w_lcnt),
    .o_frame_wrap (w_frame_wrap)
  );

  // Decode in 32-bit arithmetic so porch/sync bounds need no per-width casts.
  assign w_p32     = 32'(w_pcnt);
  assign w_l32     = 32'(w_lcnt);
  assign w_x32     = w_p32 - 32'(HSTART);
  assign w_y32     = w_l32 - 32'(VSTART);
  assign w_active  = (w_p32 >= 32'(HSTART)) && (w_l32 >= 32'(VSTART));
  assign w_hs_act  = (w_p32 >= 32'(HFP)) && (w_p32 < 32'(HFP + HPULSE));
  assign w_vs_act  = (w_l32 >= 32'(VFP)) && (w_l32 < 32'(VFP + VPULSE));
  assign w_first   = w_active && (w_x32 == 32'd0) && (w_y32 == 32'd0);
  assign w_bar32   = w_x32 / 32'(BAR_W);
  assign w_bar_idx = (w_bar32 > 32'd7) ? 3'd7 : w_bar32[2:0];

  // Stream pulls exactly one pixel per active cycle; the raster never waits.
  assign pix_ready = w_active && (r_cur_mode == MODE_STREAM);
  assign w_starve  = pix_ready && !pix_valid;

  // Select the next pixel colour from the frame's latched source.
  always_comb begin
    w_rgb_nxt = C_BLACK;
    if (w_active) begin
      case (r_cur_mode)
        MODE_GRID:   w_rgb_nxt = ((w_x32 % 32'd16 == 32'd0) || (w_y32 % 32'd16 == 32'd0)) ? C_WHITE : C_BLACK;
        MODE_BARS:   w_rgb_nxt = bar_color(w_bar_idx);
        MODE_STREAM: w_rgb_nxt = pix_valid ? pix_data : C_BLACK;
        default:     w_rgb_nxt = C_BLACK;
      endcase
    end
  end

  // Latch the source mode only at raster origin so a frame never mixes sources.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_origin   <= 1'b1;
      r_cur_mode <= MODE_GRID;
    end else begin
      r_origin <= w_frame_wrap;
      if (r_origin) begin
        r_cur_mode <= mode_t'(mode);
      end
    end
  end

  // Register all display outputs together so they share one cycle of latency.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_hs    <= ~HS_POL;
      r_vs    <= ~VS_POL;
      r_blank <= 1'b0;
      r_rgb   <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
      r_blank <= w_active;
      r_rgb   <= w_rgb_nxt;
      r_fs    <= w_first;
    end
  end

  // Sticky starvation flag; a new starvation wins over a same-cycle clear.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_uf <= 1'b0;
    end else if (w_starve) begin
      r_uf <= 1'b1;
    end else if (underflow_clr) begin
      r_uf <= 1'b0;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.RGB   = r_rgb;
  assign video_ifm.HS    = r_hs;
  assign video_ifm.VS    = r_vs;
  assign video_ifm.BLANK = r_blank;
  assign frame_start     = r_fs;
  assign underflow       = r_uf;

endmodule

// File: tb/tb_vga_gen.sv
// Testbench for vga_gen on a 22x7 raster (16x4 active) with a position-based reference model.
// Latency: expects every registered output to reflect the raster position one clock earlier.
// Backpressure: stream source is driven freely; pix_valid drops model starvation.
module tb_vga_gen;

  localparam int HD = 16, VD = 4;
  localparam int HF = 2, HP = 2, HB = 2;
  localparam int VF = 1, VP = 1, VB = 1;
  localparam int HT = HF + HP + HB + HD;
  localparam int VT = VF + VP + VB + VD;
  localparam int FR = HT * VT;
  localparam int HA = HF + HP + HB;
  localparam int VA = VF + VP + VB;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic [1:0]  mode, mode2;
  logic [23:0] pix_data, pix_data2;
  logic        pix_valid, pix_valid2, clr, clr2;
  logic        ready, ready2, fs, fs2, uf, uf2;

  video_if vif ();
  video_if vif2 ();

  always #5 clk = ~clk;

  vga_gen #(.HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
            .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(1'b0), .VS_POL(1'b0)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .mode(mode), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(ready), .frame_start(fs),
    .underflow(uf), .underflow_clr(clr), .video_ifm(vif));

  vga_gen #(.HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
            .VFP(VF), .VPULSE(VP), .VBP(VB), .HS_POL(1'b1), .VS_POL(1'b1)) dut2 (
    .pixel_clk(clk), .pixel_rst(rst2), .mode(mode2), .pix_data(pix_data2),
    .pix_valid(pix_valid2), .pix_ready(ready2), .frame_start(fs2),
    .underflow(uf2), .underflow_clr(clr2), .video_ifm(vif2));

  int checks = 0;
  int failures = 0;

  // Reference model state: raster step since release, latched mode, sticky underflow.
  int          m_step;
  logic [1:0]  m_mode;
  logic        m_uf;
  logic        m_xfer;
  logic        src_inc;
  logic        exp_hs, exp_vs, exp_blank, exp_fs;
  logic [23:0] exp_rgb;
  logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic logic exp_ready_now();
    int pos, p, l;
    pos = m_step % FR;
    p = pos % HT;
    l = pos / HT;
    return (p >= HA) && (l >= VA) && (m_mode == 2'd2);
  endfunction

  // Compute what the current raster position should produce, then clock it.
  task automatic tick();
    int pos, p, l, x, y, bi;
    logic act;
    pos = m_step % FR;
    p = pos % HT;
    l = pos / HT;
    act = (p >= HA) && (l >= VA);
    x = p - HA;
    y = l - VA;
    exp_hs    = !((p >= HF) && (p < HF + HP));
    exp_vs    = !((l >= VF) && (l < VF + VP));
    exp_blank = act;
    exp_fs    = act && (x == 0) && (y == 0);
    exp_rgb   = 24'h0;
    if (act) begin
      case (m_mode)
        2'd0: if ((x % 16 == 0) || (y % 16 == 0)) exp_rgb = 24'hFFFFFF;
        2'd1: begin
          bi = x / (HD / 8);
          if (bi > 7) bi = 7;
          exp_rgb = bar_tab[bi];
        end
        2'd2: exp_rgb = pix_valid ? pix_data : 24'h0;
        default: exp_rgb = 24'h0;
      endcase
    end
    m_xfer = act && (m_mode == 2'd2) && pix_valid;
    if (act && (m_mode == 2'd2) && !pix_valid) m_uf = 1'b1;
    else if (clr) m_uf = 1'b0;
    if (pos == 0) m_mode = mode;
    m_step++;
    @(posedge clk);
    #1;
    if (m_xfer && src_inc) pix_data = pix_data + 24'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    mode = 2'd2; mode2 = 2'd0;
    pix_data = 24'h0; pix_valid = 1'b1; clr = 1'b0; src_inc = 1'b0;
    pix_data2 = 24'h0; pix_valid2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vif.HS, vif.VS, vif.BLANK, fs, uf, ready} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=110000", {vif.HS, vif.VS, vif.BLANK, fs, uf, ready});
    end
    checks++;
    if (vif.RGB !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h exp=000000", vif.RGB);
    end
    checks++;
    if ({vif2.HS, vif2.VS, vif2.BLANK} !== 3'b000) begin
      failures++;
      $display("FAIL reset_pol got=%b exp=000", {vif2.HS, vif2.VS, vif2.BLANK});
    end
    mode = 2'd0;
    rst = 1'b0; rst2 = 1'b0;
    m_step = 0; m_mode = 2'd0; m_uf = 1'b0;
  endtask

  task automatic test_grid_timing();
    int n_hs, n_vs, n_bl, n_fs, n_rise, run, max_run;
    logic prev_bl;
    for (int f = 0; f < 2; f++) begin
      n_hs = 0; n_vs = 0; n_bl = 0; n_fs = 0; n_rise = 0; run = 0; max_run = 0; prev_bl = 1'b0;
      for (int i = 0; i < FR; i++) begin
        tick();
        checks++;
        if ({vif.HS, vif.VS, vif.BLANK, fs, vif.RGB} !== {exp_hs, exp_vs, exp_blank, exp_fs, exp_rgb}) begin
          failures++;
          $display("FAIL grid_pix step=%0d got=%h exp=%h", m_step,
                   {vif.HS, vif.VS, vif.BLANK, fs, vif.RGB}, {exp_hs, exp_vs, exp_blank, exp_fs, exp_rgb});
        end
        if (vif.HS === 1'b0) n_hs++;
        if (vif.VS === 1'b0) begin n_vs++; run++; if (run > max_run) max_run = run; end
        else run = 0;
        if (vif.BLANK === 1'b1) begin n_bl++; if (!prev_bl) n_rise++; end
        if (fs === 1'b1) begin
          n_fs++;
          checks++;
          if (prev_bl !== 1'b0 || vif.BLANK !== 1'b1) begin
            failures++;
            $display("FAIL fs_align prev_blank=%b blank=%b exp=0/1", prev_bl, vif.BLANK);
          end
        end
        prev_bl = vif.BLANK;
      end
      checks++;
      if ({n_hs, n_vs, max_run, n_bl, n_rise, n_fs} !== {32'd14, 32'd22, 32'd22, 32'd64, 32'd4, 32'd1}) begin
        failures++;
        $display("FAIL frame_counts hs=%0d vs=%0d vsrun=%0d blank=%0d runs=%0d fs=%0d exp=14/22/22/64/4/1",
                 n_hs, n_vs, max_run, n_bl, n_rise, n_fs);
      end
    end
  endtask

  task automatic test_polarity();
    int n_hs, n_vs;
    n_hs = 0; n_vs = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++;
      if ({vif2.HS, vif2.VS, vif2.BLANK, fs2} !== {!exp_hs, !exp_vs, exp_blank, exp_fs}) begin
        failures++;
        $display("FAIL pol_sync step=%0d got=%b exp=%b", m_step,
                 {vif2.HS, vif2.VS, vif2.BLANK, fs2}, {!exp_hs, !exp_vs, exp_blank, exp_fs});
      end
      if (vif2.HS === 1'b1) n_hs++;
      if (vif2.VS === 1'b1) n_vs++;
    end
    checks++;
    if (n_hs != 14 || n_vs != 22) begin
      failures++;
      $display("FAIL pol_counts hs_high=%0d vs_high=%0d exp=14/22", n_hs, n_vs);
    end
  endtask

  task automatic test_bars();
    logic [23:0] row0 [HD];
    int pp, px, py;
    mode = 2'd1;
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++;
      if ({vif.BLANK, vif.RGB} !== {exp_blank, exp_rgb}) begin
        failures++;
        $display("FAIL bars_pix step=%0d got=%h exp=%h", m_step, {vif.BLANK, vif.RGB}, {exp_blank, exp_rgb});
      end
      pp = (m_step - 1) % FR;
      px = pp % HT - HA;
      py = pp / HT - VA;
      if (px >= 0 && py >= 0) begin
        if (py == 0) row0[px] = vif.RGB;
        else begin
          checks++;
          if (vif.RGB !== row0[px]) begin
            failures++;
            $display("FAIL bars_rows x=%0d y=%0d got=%h exp=%h", px, py, vif.RGB, row0[px]);
          end
        end
      end
    end
  endtask

  task automatic test_stream_inc();
    int n_rdy, k;
    mode = 2'd2; pix_valid = 1'b1; pix_data = 24'h0; src_inc = 1'b1;
    n_rdy = 0; k = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      checks++;
      if ({vif.BLANK, vif.RGB, uf, ready} !== {exp_blank, exp_rgb, m_uf, exp_ready_now()}) begin
        failures++;
        $display("FAIL stream_pix step=%0d got=%h exp=%h", m_step,
                 {vif.BLANK, vif.RGB, uf, ready}, {exp_blank, exp_rgb, m_uf, exp_ready_now()});
      end
      if (ready === 1'b1) n_rdy++;
      if (vif.BLANK === 1'b1) begin
        checks++;
        if (vif.RGB !== 24'(k)) begin
          failures++;
          $display("FAIL stream_seq idx=%0d got=%h exp=%h", k, vif.RGB, 24'(k));
        end
        k++;
      end
    end
    checks++;
    if (n_rdy != 64 || uf !== 1'b0) begin
      failures++;
      $display("FAIL stream_count ready=%0d uf=%b exp=64/0", n_rdy, uf);
    end
  endtask

  task automatic test_underflow();
    int pos;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FR; i++) begin
        pos = m_step % FR;
        pix_valid = (pos != 5 * HT + 11);
        clr = (f == 1) && ((pos == 5 * HT + 11) || (pos == 5 * HT + 19));
        tick();
        checks++;
        if ({vif.HS, vif.VS, vif.BLANK, vif.RGB, uf} !== {exp_hs, exp_vs, exp_blank, exp_rgb, m_uf}) begin
          failures++;
          $display("FAIL uf_pix step=%0d got=%h exp=%h", m_step,
                   {vif.HS, vif.VS, vif.BLANK, vif.RGB, uf}, {exp_hs, exp_vs, exp_blank, exp_rgb, m_uf});
        end
        if (pos == 5 * HT + 11) begin
          checks++;
          if ({vif.BLANK, vif.RGB, uf} !== {1'b1, 24'h0, 1'b1}) begin
            failures++;
            $display("FAIL uf_drop frame=%0d got=%h exp=%h", f, {vif.BLANK, vif.RGB, uf}, {1'b1, 24'h0, 1'b1});
          end
        end
        if (f == 1 && pos == 5 * HT + 19) begin
          checks++;
          if (uf !== 1'b0) begin
            failures++;
            $display("FAIL uf_clear got=%b exp=0", uf);
          end
        end
      end
      if (f == 0) begin
        checks++;
        if (uf !== 1'b1) begin
          failures++;
          $display("FAIL uf_sticky got=%b exp=1", uf);
        end
      end
    end
    clr = 1'b0; pix_valid = 1'b1;
  endtask

  task automatic test_stream_random();
    src_inc = 1'b0;
    for (int i = 0; i < FR; i++) begin
      pix_valid = ($urandom % 5) != 0;
      pix_data  = 24'($urandom);
      clr       = ($urandom % 16) == 0;
      tick();
      checks++;
      if ({vif.BLANK, vif.RGB, uf, ready} !== {exp_blank, exp_rgb, m_uf, exp_ready_now()}) begin
        failures++;
        $display("FAIL rand_pix step=%0d got=%h exp=%h", m_step,
                 {vif.BLANK, vif.RGB, uf, ready}, {exp_blank, exp_rgb, m_uf, exp_ready_now()});
      end
    end
    clr = 1'b0; pix_valid = 1'b1;
  endtask

  task automatic test_mode_switch();
    int pos;
    logic [23:0] want;
    mode = 2'd0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FR; i++) begin
        pos = m_step % FR;
        if (f == 0 && pos == 5 * HT) mode = 2'd1;
        tick();
        checks++;
        if ({vif.BLANK, vif.RGB, ready} !== {exp_blank, exp_rgb, exp_ready_now()}) begin
          failures++;
          $display("FAIL switch_pix step=%0d got=%h exp=%h", m_step,
                   {vif.BLANK, vif.RGB, ready}, {exp_blank, exp_rgb, exp_ready_now()});
        end
        if (pos == 6 * HT + 8) begin
          want = (f == 0) ? 24'h000000 : 24'hFFFF00;
          checks++;
          if (vif.RGB !== want) begin
            failures++;
            $display("FAIL switch_frame frame=%0d got=%h exp=%h", f, vif.RGB, want);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < FR && ((m_step - 1) % FR) != 4 * HT + 8; i++) tick();
    checks++;
    if ({vif.BLANK, vif.RGB} !== {1'b1, 24'hFFFF00}) begin
      failures++;
      $display("FAIL pre_reset got=%h exp=%h", {vif.BLANK, vif.RGB}, {1'b1, 24'hFFFF00});
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({vif.HS, vif.VS, vif.BLANK, fs, vif.RGB} !== {4'b1100, 24'h0}) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", {vif.HS, vif.VS, vif.BLANK, fs, vif.RGB}, {4'b1100, 24'h0});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_step = 0; m_mode = 2'd0; m_uf = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (vif.HS !== (k < 3)) begin
        failures++;
        $display("FAIL restart_hs edge=%0d got=%b exp=%b", k, vif.HS, (k < 3));
      end
    end
    for (int i = 3; i < FR; i++) begin
      tick();
      checks++;
      if ({vif.HS, vif.VS, vif.BLANK, fs, vif.RGB} !== {exp_hs, exp_vs, exp_blank, exp_fs, exp_rgb}) begin
        failures++;
        $display("FAIL restart_pix step=%0d got=%h exp=%h", m_step,
                 {vif.HS, vif.VS, vif.BLANK, fs, vif.RGB}, {exp_hs, exp_vs, exp_blank, exp_fs, exp_rgb});
      end
    end
  endtask

  initial begin
    test_reset();
    test_grid_timing();
    test_polarity();
    test_bars();
    test_stream_inc();
    test_underflow();
    test_stream_random();
    test_mode_switch();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
